// File: rtl/ps_frame_pkg.sv
// ps_frame_pkg
// Shared definitions for the trigger-frame scheduler: frame geometry,
// FSM state encoding and the CRC-8 byte update used on the link.
// No ports (package).
package ps_frame_pkg;

  localparam int         FRAME_LEN     = 10;
  localparam logic [3:0] PAYLOAD_BYTES = 4'd7;
  localparam logic [3:0] CRC_IDX       = 4'd8;
  localparam logic [3:0] END_IDX       = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Non-reflected, MSB-first CRC-8, one byte per call, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ps_frame_scheduler_if.sv
// ps_frame_scheduler_if
// Byte stream from the scheduler to the serial link transmitter.
//   tx_data  : frame byte
//   tx_valid : tx_data valid
//   tx_ready : downstream accepts the byte when tx_valid & tx_ready
//   tx_sof   : marks byte 0 (header)
//   tx_eof   : marks byte 9 (END)
// master = scheduler side, slave = transmitter side.
interface ps_frame_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sof;
  logic       tx_eof;

  modport master (
    output tx_data, tx_valid, tx_sof, tx_eof,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, tx_sof, tx_eof,
    output tx_ready
  );
endinterface

// File: rtl/ps_rr_arbiter.sv
// ps_rr_arbiter
// Combinational round-robin pick: first asserted request searching upward
// from ptr+1 and wrapping, so the last winner has lowest priority.
//   req    : request vector
//   ptr    : index of the previous winner
//   winner : selected requester index (valid only when valid=1)
//   valid  : at least one request asserted
module ps_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               valid
);

  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the nearest asserted request is the
  // last one written and therefore wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |req;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = PW'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ps_frame_scheduler.sv
// ps_frame_scheduler
// Round-robin arbitrates trigger requests and serialises the winner into a
// 10-byte frame (header, 7 payload bytes, CRC-8, END) with ready/valid
// backpressure and a programmable idle gap after each frame.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : gates the start of new frames only
//   req        : per-requester level request
//   payload    : 56 bits per requester, byte 1 in the top byte
//   ack        : one-cycle pulse when a requester's payload is captured
//   busy       : high in SEND or GAP
//   tx         : byte stream to the link transmitter (master modport)
//
// state | meaning
// IDLE  | waiting for enable & a request; outputs idle
// SEND  | presenting frame bytes 0..9, advancing on tx_ready
// GAP   | forced idle cycles after END is accepted
module ps_frame_scheduler
  import ps_frame_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] HDR_TAG    = 4'hA,
  parameter logic [7:0] END_BYTE   = 8'h5A,
  parameter int         GAP_CYCLES = 2,
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] CRC_INIT   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*56-1:0] payload,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  busy,
  ps_frame_scheduler_if.master  tx
);

  localparam int            PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);
  // Counter runs GAP_LOAD..0, giving exactly GAP_CYCLES cycles in GAP.
  localparam logic [3:0]    GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state_q, state_d;
  logic [3:0]           byte_idx_q, byte_idx_d;
  logic [7:0]           crc_q, crc_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [3:0]           winner_q, winner_d;
  logic [55:0]          payload_q, payload_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [PW-1:0]        arb_winner;
  logic                 arb_valid;
  logic [55:0]          sel_payload;
  logic [55:0]          pay_shift;
  logic [7:0]           tx_byte;
  logic                 accept;

  ps_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_winner == PW'(i)) begin
        sel_payload = payload[i*56 +: 56];
      end
    end
  end

  // Payload bytes come out MSB first: byte k sits in the top byte after
  // shifting left by k-1 bytes.
  always_comb begin
    tx_byte   = 8'h00;
    pay_shift = payload_q << {byte_idx_q - 4'd1, 3'b000};
    if (state_q == SEND) begin
      if (byte_idx_q == 4'd0) begin
        tx_byte = {HDR_TAG, winner_q};
      end else if (byte_idx_q <= PAYLOAD_BYTES) begin
        tx_byte = pay_shift[55:48];
      end else if (byte_idx_q == CRC_IDX) begin
        tx_byte = crc_q;
      end else begin
        tx_byte = END_BYTE;
      end
    end
  end

  assign accept      = (state_q == SEND) && tx.tx_ready;
  assign tx.tx_data  = tx_byte;
  assign tx.tx_valid = (state_q == SEND);
  assign tx.tx_sof   = (state_q == SEND) && (byte_idx_q == 4'd0);
  assign tx.tx_eof   = (state_q == SEND) && (byte_idx_q == END_IDX);
  assign busy        = (state_q != IDLE);
  assign ack         = ack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 4'd0;
      crc_q      <= CRC_INIT;
      ptr_q      <= PTR_RESET;
      winner_q   <= 4'd0;
      payload_q  <= '0;
      gap_cnt_q  <= 4'd0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      crc_q      <= crc_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      payload_q  <= payload_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    crc_d      = crc_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    payload_d  = payload_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;

    case (state_q)
      IDLE: begin
        if (enable && arb_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (arb_winner == PW'(i));
          end
          ptr_d      = arb_winner;
          winner_d   = 4'(arb_winner);
          payload_d  = sel_payload;
          byte_idx_d = 4'd0;
          crc_d      = CRC_INIT;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (accept) begin
          if (byte_idx_q == END_IDX) begin
            byte_idx_d = 4'd0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_d = GAP_LOAD;
              state_d   = GAP;
            end else begin
              state_d   = IDLE;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            if (byte_idx_q < CRC_IDX) begin
              crc_d = crc8_update(crc_q, tx_byte, POLYNOMIAL);
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ps_frame_scheduler.md
Name: ps_frame_scheduler

Overview:
Shares the single CRC-8 protected trigger byte link between NUM_REQ requesters. It round-robin arbitrates pending trigger messages and serialises the winner into a 10-byte frame:
- header byte
- 7 payload bytes
- CRC-8 byte
- END byte

It applies downstream ready/valid backpressure and enforces a programmable inter-frame gap. It sits between the trigger sources and the serial link transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
HDR_TAG, 4'hA, upper nibble of header byte
END_BYTE, 8'h5A, byte 9 of every frame
GAP_CYCLES, 2, idle cycles forced after byte 9 accepted (0..15)
POLYNOMIAL, 8'h07, CRC-8 polynomial
CRC_INIT, 8'hFF, CRC-8 seed

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  when low, no new frame starts; a frame in progress completes
req  in  NUM_REQ  per-requester level request
payload  in  NUM_REQ*56  requester i uses bits [56*i+55:56*i]; byte 1 = bits [55:48] (MSB first)
ack  out  NUM_REQ  one-cycle pulse: payload of requester i captured
tx_data  out  8  frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts byte when tx_valid & tx_ready
tx_sof  out  1  high with byte 0 while tx_valid
tx_eof  out  1  high with byte 9 while tx_valid
busy  out  1  high in SEND or GAP

Behaviour:
- Reset values: ack=0, tx_data=8'h00, tx_valid=0, tx_sof=0, tx_eof=0, busy=0, state=IDLE, byte_idx=0, crc=CRC_INIT, rr pointer=NUM_REQ-1 (requester 0 has first priority).
- States: IDLE, SEND, GAP.
- IDLE, when enable & |req at a clock edge:
  - winner = first asserted req searching upward from pointer+1, wrapping.
  - Capture the winner's payload; ack[winner]=1 for the next cycle only.
  - pointer<=winner; byte_idx<=0; crc<=CRC_INIT; state<=SEND.
  - Latency: req high → tx_valid high exactly 1 cycle later.
- IDLE otherwise: tx_valid=0, tx_data=8'h00.
- req is sampled only in IDLE; requests deasserted before grant are lost silently. Non-winners keep waiting.
- SEND: tx_valid=1. tx_data by byte_idx:
  - 0: {HDR_TAG, winner[3:0]}
  - 1..7: payload bytes MSB first
  - 8: crc register
  - 9: END_BYTE
- SEND handshake: on tx_valid & tx_ready, byte_idx increments. For byte_idx 0..7, crc <= crc8_update(crc, tx_data).
- CRC-8 definition: non-reflected, MSB-first, no final XOR, 1 byte/cycle.
- Backpressure: with tx_ready low, tx_data, tx_sof, tx_eof and byte_idx hold unchanged, and crc is not updated.
- tx_sof = (byte_idx==0) & tx_valid; tx_eof = (byte_idx==9) & tx_valid.
- Byte 9 accepted: byte_idx<=0; state<=GAP if GAP_CYCLES>0, else IDLE.
- GAP: tx_valid=0; a 4-bit down-counter loaded with GAP_CYCLES; IDLE when it expires.
- Minimum spacing between last END byte accepted and next tx_sof: GAP_CYCLES+2 cycles.
- enable deassert during SEND/GAP: no effect until IDLE.
- req/payload changes during SEND: ignored (payload already captured).
- Asynchronous reset mid-frame: frame abandoned, outputs go to reset values immediately, pending acks are not issued.

Decomposition:
- Package ps_frame_pkg holds:
  - FRAME_LEN=10, CRC_IDX=8, END_IDX=9, PAYLOAD_BYTES=7
  - state enum {IDLE, SEND, GAP}
  - function crc8_update(crc, byte, poly)
- Sub-module ps_rr_arbiter (combinational winner + valid from req and pointer).
- Pointer register and all sequencing stay in ps_frame_scheduler.

Test Plan:
- Single frame: req=4'b0100, payload[2]=56'h11223344556677, tx_ready=1 → ack[2] pulse 1 cycle. tx_data sequence A2,11,22,33,44,55,66,77,C,5A on consecutive cycles. CRC-8 (init FF) recomputed over bytes 0..8 equals 8'h00. tx_sof on A2, tx_eof on 5A.
- Round-robin: req=4'b1111 held, acks pulsed → grant order 0,1,2,3,0. Headers A0,A1,A2,A3,A0. Each tx_sof is 4 cycles (GAP_CYCLES+2) after the previous END byte is accepted.
- Backpressure: tx_ready low for 3 cycles at byte_idx 4 and at byte_idx 8 → tx_data held constant. Byte sequence and CRC identical to the no-stall run.
- enable: enable=0 with req=4'b0001 → no ack, tx_valid=0. Drop enable mid-frame → frame completes, then no new sof. Re-enable → frame starts 1 cycle later.
- Reset mid-frame: assert reset at byte_idx 5 → tx_valid=0 immediately. After release with req=4'b1000|4'b0001 → requester 0 wins first (header A0).
- GAP_CYCLES=0 with continuous req → exactly one idle cycle (IDLE) between END accepted and the next header.
